// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and source-select encoding for the register file write port.
package regfile_write_arbiter_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned NUM_REGS  = 32;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_PIPE   = 2'd1,
        SRC_FIFO   = 2'd2,
        SRC_BYPASS = 2'd3
    } src_sel_e;

endpackage

// File: rtl/regfile_write_arbiter_wb_result_fifo.sv
// Circular buffer of long-latency {RW, BusW} results; push and pop may coincide.
module wb_result_fifo #(
    parameter int unsigned W     = 37,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges writeback and long-latency results onto one registered register file
// write port and tracks registers still awaiting a long-latency result.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    PipeWr,
    input  logic [ADDR_W-1:0]       PipeRW,
    input  logic [DATA_W-1:0]       PipeBusW,
    input  logic                    IssueValid,
    input  logic [ADDR_W-1:0]       IssueRW,
    input  logic                    LongValid,
    input  logic [ADDR_W-1:0]       LongRW,
    input  logic [DATA_W-1:0]       LongBusW,
    output logic                    LongReady,
    output logic                    RegWr,
    output logic [ADDR_W-1:0]       RW,
    output logic [DATA_W-1:0]       BusW,
    output logic [NUM_REGS-1:0]     Pending,
    output logic [$clog2(DEPTH):0]  Count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = ADDR_W + DATA_W;

    src_sel_e            src;
    logic                accept;
    logic                push;
    logic                pop;
    logic [ENT_W-1:0]    head;
    logic [ADDR_W-1:0]   head_rw;
    logic [DATA_W-1:0]   head_data;
    logic [ADDR_W-1:0]   sel_rw;
    logic [DATA_W-1:0]   sel_data;
    logic                long_flag;
    logic [NUM_REGS-1:0] pending_nxt;

    assign LongReady            = !Rst && (Count < CNT_W'(DEPTH));
    assign accept               = LongValid && LongReady;
    assign {head_rw, head_data} = head;

    wb_result_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (Clk),
        .rst       (Rst),
        .push      (push),
        .push_data ({LongRW, LongBusW}),
        .pop       (pop),
        .count     (Count),
        .head      (head)
    );

    // Source selection; a pipe write to R0 yields the port to the long path.
    always_comb begin
        src      = SRC_NONE;
        sel_rw   = '0;
        sel_data = '0;
        if (PipeWr && (PipeRW != '0)) begin
            src      = SRC_PIPE;
            sel_rw   = PipeRW;
            sel_data = PipeBusW;
        end else if (Count != '0) begin
            src      = SRC_FIFO;
            sel_rw   = head_rw;
            sel_data = head_data;
        end else if (accept) begin
            src      = SRC_BYPASS;
            sel_rw   = LongRW;
            sel_data = LongBusW;
        end
        push = accept && (src != SRC_BYPASS);
        pop  = (src == SRC_FIFO);
    end

    // Clear on the commit edge of a long write; a same-edge issue wins.
    always_comb begin
        pending_nxt = Pending;
        if (RegWr && long_flag) pending_nxt[RW] = 1'b0;
        if (IssueValid && (IssueRW != '0)) pending_nxt[IssueRW] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            RegWr     <= 1'b0;
            RW        <= '0;
            BusW      <= '0;
            long_flag <= 1'b0;
            Pending   <= '0;
        end else begin
            RegWr     <= (src != SRC_NONE) && (sel_rw != '0);
            long_flag <= (src == SRC_FIFO) || (src == SRC_BYPASS);
            Pending   <= pending_nxt;
            if (src != SRC_NONE) begin
                RW   <= sel_rw;
                BusW <= sel_data;
            end
        end
    end

endmodule
